multiplicador_seq: RTL and testbench
====================================

# multiplicador_seq

Parametrised sequential shift-add multiplier. It is the next generation of the 8-bit serial multiplier in the arithmetic datapath, with these additions: operand width N, signed or unsigned mode per operation, a START/BUSY/DONE handshake, a full 2N-bit product, and a synchronous reset. It consumes one multiplier bit per clock and drives the truncated N-bit result with an overflow flag toward the display/ALU path.

## Interface
- N, default 8, operand width; legal range 2..32
- CK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- START  in  1  request; sampled only when BUSY=0
- SIGNED  in  1  mode, sampled with START; 1 = two's complement, 0 = unsigned
- A  in  N  multiplicand, sampled with START
- B  in  N  multiplier, sampled with START
- BUSY  out  1  high while the operation is being calculated
- DONE  out  1  one-cycle pulse; result is valid
- P  out  2N  full product
- S  out  N  low half of product, P[N-1:0]
- OV  out  1  overflow: the product does not fit in N bits for the sampled mode

## Operation
- States: IDLE, CALC, FIM.
- IDLE with START=1:
  - Latch the operands as magnitudes: in signed mode, |A| and |B| (two's-complement negate when the MSB is set); in unsigned mode, A and B as given.
  - Latch neg = SIGNED & (A[N-1] ^ B[N-1]).
  - Clear the 2N-bit accumulator and the bit counter, then go to CALC.
- CALC, per cycle:
  - If the current multiplier bit is 1, add the multiplicand shifted left by the counter into the accumulator.
  - Increment the counter.
  - After the bit of index N-1 is consumed, go to FIM.
- Magnitude of the most-negative value (e.g. -128 for N=8) is 2^(N-1). This must be handled as an unsigned N-bit value, with no wrap.
- Register update on the CALC→FIM transition:
  - P = neg ? -acc : acc, computed modulo 2^2N.
  - S = P[N-1:0].
  - OV, unsigned mode: OV = |P[2N-1:N].
  - OV, signed mode: OV = 1 unless every bit of P[2N-1:N-1] is equal.
- FIM: DONE=1 and BUSY=0 for exactly one cycle.
  - START=1 in FIM is accepted and goes directly to CALC, giving back-to-back operations.
  - Otherwise go to IDLE.
- P, S and OV hold their value until the next FIM update. They are not cleared by a new START.
- START while BUSY=1 is ignored. No queuing, no error flag.
- A, B and SIGNED may change freely after the sampling edge.
- Zero operand: the full N cycles still run, so latency is fixed. Result is P=0, OV=0.

## Timing
- Reset values: state IDLE, BUSY=0, DONE=0, P=0, S=0, OV=0, accumulator and counter 0.
- START sampled at edge t:
  - BUSY=1 for the cycles following edges t .. t+N-1 (N cycles).
  - DONE=1 and new P/S/OV are visible in the cycle following edge t+N.
  - Latency is N+1 edges, regardless of operand values.
- Back-to-back throughput: one result every N+1 cycles.
- RST=1 at any edge takes priority over everything else. The state returns to the reset values and any in-flight operation is discarded; its result never appears and DONE does not pulse.
- RST and START asserted together: reset wins and START is lost.
- Outputs are registered only. There are no combinational paths from inputs to outputs.

## Test plan
- N=8, unsigned, A=15, B=13 → after 9 edges, DONE pulse, P=0x00C3 (195), S=0xC3, OV=0. BUSY is high for exactly 8 cycles.
- N=8, unsigned, A=255, B=255 → P=0xFE01, S=0x01, OV=1. Also A=0, B=200 → P=0, OV=0 with the same 9-edge latency.
- N=8, signed:
  - A=0xFD (-3), B=0x05 → P=0xFFF1, S=0xF1, OV=0.
  - A=0x80, B=0x80 (-128×-128) → P=0x4000, OV=1.
  - A=0x80, B=0x01 → P=0xFF80, OV=0.
- N=8, START A=10, B=10, with START re-asserted on cycles 2 and 5 carrying A=3, B=3 → both ignored. Result is 100. START asserted in the FIM cycle with A=3, B=3 → second DONE 9 cycles later with P=9, and P holds 100 in between.
- N=8, assert RST at cycle 4 of a calculation → BUSY=0 and P=0 next cycle, and no DONE pulse. Repeat with RST and START asserted together → operation not started.
- N=16, unsigned, A=0xFFFF, B=0x0002 → P=0x0001FFFE, OV=1, latency 17 edges. N=4 signed, A=0x7, B=0x7 → P=0x31, OV=1.

Source files
------------

// File: rtl/multiplicador_seq.sv
// Sequential shift-add multiplier: one multiplier bit per clock, signed or unsigned per operation,
// with a START/BUSY/DONE handshake and registered 2N-bit product, N-bit truncation and overflow.
module multiplicador_seq #(
  parameter int unsigned N = 8
) (
  input  logic           CK,
  input  logic           RST,
  input  logic           START,
  input  logic           SIGNED,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           BUSY,
  output logic           DONE,
  output logic [2*N-1:0] P,
  output logic [N-1:0]   S,
  output logic           OV
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFim} state_e;

  state_e         state_q;
  logic [N-1:0]   mcand_q;
  logic [N-1:0]   mplier_q;
  logic           neg_q;
  logic           sgn_q;
  logic [2*N-1:0] acc_q;
  logic [CntW-1:0] cnt_q;

  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic           neg_in;
  logic [2*N-1:0] addend;
  logic [2*N-1:0] acc_nxt;
  logic [2*N-1:0] prod;
  logic           ov_nxt;
  logic           last_bit;

  always_comb begin
    // Negating the most-negative value yields 2^(N-1), which is exact as an unsigned magnitude.
    mag_a    = (SIGNED && A[N-1]) ? -A : A;
    mag_b    = (SIGNED && B[N-1]) ? -B : B;
    neg_in   = SIGNED & (A[N-1] ^ B[N-1]);
    addend   = mplier_q[cnt_q] ? ({{N{1'b0}}, mcand_q} << cnt_q) : '0;
    acc_nxt  = acc_q + addend;
    prod     = neg_q ? -acc_nxt : acc_nxt;
    // Signed result fits only if the upper half plus the sign bit of S are all copies of one bit.
    ov_nxt   = sgn_q ? !((&prod[2*N-1:N-1]) || !(|prod[2*N-1:N-1])) : (|prod[2*N-1:N]);
    last_bit = (cnt_q == CntW'(N - 1));
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      P        <= '0;
      S        <= '0;
      OV       <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state_q)
        StIdle, StFim: begin
          if (START) begin
            mcand_q  <= mag_a;
            mplier_q <= mag_b;
            neg_q    <= neg_in;
            sgn_q    <= SIGNED;
            acc_q    <= '0;
            cnt_q    <= '0;
            BUSY     <= 1'b1;
            state_q  <= StCalc;
          end else begin
            state_q <= StIdle;
          end
        end
        StCalc: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + CntW'(1);
          if (last_bit) begin
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            P       <= prod;
            S       <= prod[N-1:0];
            OV      <= ov_nxt;
            state_q <= StFim;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_seq.sv
// Self-checking bench for multiplicador_seq at N=8, 16 and 4 against an integer-arithmetic model.
module tb_multiplicador_seq;

  logic        ck = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] a_bus;
  logic [31:0] b_bus;

  logic        busy8, done8, ov8;
  logic [15:0] p8;
  logic [7:0]  s8;
  logic        busy16, done16, ov16;
  logic [31:0] p16;
  logic [15:0] s16;
  logic        busy4, done4, ov4;
  logic [7:0]  p4;
  logic [3:0]  s4;

  int          sel;
  logic        obs_busy, obs_done, obs_ov;
  longint      obs_p, obs_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ck = ~ck;

  multiplicador_seq #(.N(8)) u_dut8 (
    .CK(ck), .RST(rst), .START(start), .SIGNED(sgn), .A(a_bus[7:0]), .B(b_bus[7:0]),
    .BUSY(busy8), .DONE(done8), .P(p8), .S(s8), .OV(ov8)
  );

  multiplicador_seq #(.N(16)) u_dut16 (
    .CK(ck), .RST(rst), .START(start), .SIGNED(sgn), .A(a_bus[15:0]), .B(b_bus[15:0]),
    .BUSY(busy16), .DONE(done16), .P(p16), .S(s16), .OV(ov16)
  );

  multiplicador_seq #(.N(4)) u_dut4 (
    .CK(ck), .RST(rst), .START(start), .SIGNED(sgn), .A(a_bus[3:0]), .B(b_bus[3:0]),
    .BUSY(busy4), .DONE(done4), .P(p4), .S(s4), .OV(ov4)
  );

  always_comb begin
    obs_busy = busy8;
    obs_done = done8;
    obs_ov   = ov8;
    obs_p    = longint'(p8);
    obs_s    = longint'(s8);
    case (sel)
      16: begin
        obs_busy = busy16; obs_done = done16; obs_ov = ov16;
        obs_p = longint'(p16); obs_s = longint'(s16);
      end
      4: begin
        obs_busy = busy4; obs_done = done4; obs_ov = ov4;
        obs_p = longint'(p4); obs_s = longint'(s4);
      end
      default: ;
    endcase
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands as integers, multiply, then reduce.
  task automatic model(input int n, input bit sg, input longint a, input longint b,
                       output longint p, output bit ov);
    longint sa, sb, prod, half;
    sa = a;
    sb = b;
    half = longint'(1) << (n - 1);
    if (sg && a >= half) sa = a - (longint'(1) << n);
    if (sg && b >= half) sb = b - (longint'(1) << n);
    prod = sa * sb;
    p = prod & ((longint'(1) << (2 * n)) - 1);
    if (sg) ov = (prod < -half) || (prod >= half);
    else    ov = (prod >= (longint'(1) << n));
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic run_op(input int n, input bit sg, input longint a, input longint b);
    longint ep;
    bit     eov;
    int     busy_cnt;
    bit     early;
    model(n, sg, a, b, ep, eov);
    sel   = n;
    start = 1'b1;
    sgn   = sg;
    a_bus = 32'(a);
    b_bus = 32'(b);
    tick();
    start = 1'b0;
    a_bus = $urandom;
    b_bus = $urandom;
    sgn   = ~sg;
    busy_cnt = 0;
    early    = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (obs_busy) busy_cnt++;
      if (obs_done) early = 1'b1;
      tick();
    end
    check_val("busy_cycles", longint'(busy_cnt), longint'(n));
    check_val("early_done", longint'(early), 0);
    check_val("done", longint'(obs_done), 1);
    check_val("busy_at_done", longint'(obs_busy), 0);
    check_val("p", obs_p, ep);
    check_val("s", obs_s, ep & ((longint'(1) << n) - 1));
    check_val("ov", longint'(obs_ov), longint'(eov));
    tick();
    check_val("done_pulse", longint'(obs_done), 0);
  endtask

  initial begin
    sel   = 8;
    rst   = 1'b1;
    start = 1'b0;
    sgn   = 1'b0;
    a_bus = '0;
    b_bus = '0;
    tick();
    tick();
    check_val("rst_busy", longint'(obs_busy), 0);
    check_val("rst_done", longint'(obs_done), 0);
    check_val("rst_p", obs_p, 0);
    check_val("rst_s", obs_s, 0);
    check_val("rst_ov", longint'(obs_ov), 0);
    rst = 1'b0;
    tick();

    run_op(8, 1'b0, 15, 13);
    check_val("p_15x13", obs_p, 'h00C3);
    run_op(8, 1'b0, 255, 255);
    run_op(8, 1'b0, 0, 200);
    run_op(8, 1'b1, 'hFD, 'h05);
    run_op(8, 1'b1, 'h80, 'h80);
    check_val("ov_m128sq", longint'(obs_ov), 1);
    run_op(8, 1'b1, 'h80, 'h01);
    for (int i = 0; i < 40; i++)
      run_op(8, 1'($urandom_range(0, 1)), longint'($urandom_range(0, 255)),
             longint'($urandom_range(0, 255)));

    // START while busy is ignored; START in the DONE cycle chains a second operation.
    sel   = 8;
    sgn   = 1'b0;
    start = 1'b1;
    a_bus = 10;
    b_bus = 10;
    tick();
    for (int k = 0; k < 8; k++) begin
      check_val("ign_busy", longint'(obs_busy), 1);
      start = (k == 1 || k == 4);
      a_bus = 3;
      b_bus = 3;
      tick();
    end
    check_val("ign_done", longint'(obs_done), 1);
    check_val("ign_p", obs_p, 100);
    start = 1'b1;
    a_bus = 3;
    b_bus = 3;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_val("b2b_busy", longint'(obs_busy), 1);
      check_val("b2b_hold", obs_p, 100);
      tick();
    end
    check_val("b2b_done", longint'(obs_done), 1);
    check_val("b2b_p", obs_p, 9);
    tick();

    // Reset mid-calculation discards the operation.
    start = 1'b1;
    a_bus = 200;
    b_bus = 100;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mid_rst_busy", longint'(obs_busy), 0);
    check_val("mid_rst_p", obs_p, 0);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
        if (obs_done || obs_busy) seen = 1'b1;
        tick();
      end
      check_val("mid_rst_quiet", longint'(seen), 0);
    end

    // Reset and START together: nothing starts.
    rst   = 1'b1;
    start = 1'b1;
    a_bus = 7;
    b_bus = 9;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check_val("rst_start_busy", longint'(obs_busy), 0);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
        if (obs_done || obs_busy) seen = 1'b1;
        tick();
      end
      check_val("rst_start_quiet", longint'(seen), 0);
    end

    run_op(16, 1'b0, 'hFFFF, 'h0002);
    check_val("p16_const", obs_p, 'h0001FFFE);
    for (int i = 0; i < 8; i++)
      run_op(16, 1'($urandom_range(0, 1)), longint'($urandom_range(0, 65535)),
             longint'($urandom_range(0, 65535)));
    run_op(4, 1'b1, 'h7, 'h7);
    check_val("p4_const", obs_p, 'h31);
    for (int i = 0; i < 12; i++)
      run_op(4, 1'($urandom_range(0, 1)), longint'($urandom_range(0, 15)),
             longint'($urandom_range(0, 15)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
